// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data width, MEM-stage FSM encoding,
// EX/MEM and MEM/WB field layouts, and small decode helpers.
package mips_pkg;

  localparam int DATA_W = 32;
  // Wide enough for TIMEOUT_CYC values 1..255.
  localparam int CNT_W  = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  // EX/MEM register fields consumed by the MEM stage.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rt;
    logic              mem_read;
    logic              mem_write;
  } ex_mem_t;

  // MEM/WB register fields produced by the MEM stage.
  typedef struct packed {
    logic [DATA_W-1:0] dato;
    logic [DATA_W-1:0] result;
    logic              valid;
    logic              err;
  } mem_wb_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  // Word accesses only: any set byte-offset bit is a misalignment.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register. valid_wb/mem_error are one-cycle pulses;
// result_wb and dato_leido hold until their enables load them.
module mem_wb_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wb_en,
  input  logic              ld_en,
  input  logic              err,
  input  logic [DATA_W-1:0] result_d,
  input  logic [DATA_W-1:0] dato_d,
  output logic [DATA_W-1:0] dato_leido,
  output logic [DATA_W-1:0] result_wb,
  output logic              valid_wb,
  output logic              mem_error
);

  // Pulse flags every cycle; data fields load only when enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dato_leido <= '0;
      result_wb  <= '0;
      valid_wb   <= 1'b0;
      mem_error  <= 1'b0;
    end else begin
      valid_wb  <= wb_en;
      mem_error <= wb_en & err;
      if (wb_en) result_wb  <= result_d;
      if (ld_en) dato_leido <= dato_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: issues one data-memory access at a time over a
// variable-latency req/ack port, stalls upstream while it is outstanding,
// aborts after TIMEOUT_CYC waiting cycles, and feeds the MEM/WB register.
module mem_stage #(
  parameter int DATA_W      = mips_pkg::DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] registro_2,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] dato_leido,
  output logic [DATA_W-1:0] result_wb,
  output logic              valid_wb,
  output logic              mem_error
);
  import mips_pkg::*;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic mem_op, op_err, in_idle, in_access;
  logic issue, done, tmo;
  logic wb_en, ld_en, wb_err;
  logic [DATA_W-1:0] wb_result, wb_dato;

  // Decode of the instruction sitting in EX/MEM.
  always_comb begin
    mem_op    = mem_read | mem_write;
    op_err    = mem_op & (misaligned(result[1:0]) | (mem_read & mem_write));
    in_idle   = (state_q == ST_IDLE);
    in_access = (state_q == ST_ACCESS);
    issue     = in_idle & valid_in & mem_op & ~op_err;
    // Ack beats timeout when both land in the last waiting cycle.
    done      = in_access & dmem_ack;
    tmo       = in_access & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    // Gated by reset so upstream never sees a stall while reset is held.
    stall     = reset_n & (issue | (in_access & ~dmem_ack & ~tmo));
  end

  // Next-state logic: one access in flight, return to IDLE on ack or abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (issue)       state_d = ST_ACCESS;
      ST_ACCESS: if (done || tmo) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Waiting-cycle counter, cleared at issue and on leaving ACCESS.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               cnt_q <= '0;
    else if (issue)             cnt_q <= '0;
    else if (done || tmo)       cnt_q <= '0;
    else if (in_access)         cnt_q <= cnt_q + 1'b1;
  end

  // Request registers: captured at issue, held stable until ack/abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write;
      dmem_addr  <= {result[DATA_W-1:2], 2'b00};
      dmem_wdata <= registro_2;
    end else if (done || tmo) begin
      dmem_req   <= 1'b0;
    end
  end

  // MEM/WB entry sources: IDLE retires ALU ops and rejected ops directly,
  // ACCESS retires on ack or timeout with the latched address.
  always_comb begin
    wb_en     = (in_idle & valid_in & ~issue) | done | tmo;
    wb_err    = (in_idle & op_err) | tmo;
    wb_result = in_idle ? result : dmem_addr;
    ld_en     = (in_idle & valid_in & ~mem_op) | (done & ~dmem_we);
    wb_dato   = in_idle ? '0 : dmem_rdata;
  end

  mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb_reg (
    .clock      (clock),
    .reset_n    (reset_n),
    .wb_en      (wb_en),
    .ld_en      (ld_en),
    .err        (wb_err),
    .result_d   (wb_result),
    .dato_d     (wb_dato),
    .dato_leido (dato_leido),
    .result_wb  (result_wb),
    .valid_wb   (valid_wb),
    .mem_error  (mem_error)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of single-cycle cases, directed multi-cycle
// corner cases, and random instruction streams against a transaction model.
module tb_mem_stage;

  localparam int T = 4;

  logic        clock = 0, reset_n = 0;
  logic        valid_in = 0, mem_read = 0, mem_write = 0;
  logic [31:0] result = 0, registro_2 = 0;
  logic        stall, dmem_req, dmem_we, dmem_ack = 0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [31:0] dato_leido, result_wb;
  logic        valid_wb, mem_error;

  int n_pass = 0, n_total = 0;
  logic [31:0] m_dato = 0;
  logic        m_dato_known = 1;

  mem_stage #(.DATA_W(32), .TIMEOUT_CYC(T)) dut (
    .clock(clock), .reset_n(reset_n), .valid_in(valid_in), .result(result),
    .registro_2(registro_2), .mem_read(mem_read), .mem_write(mem_write),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dato_leido(dato_leido), .result_wb(result_wb), .valid_wb(valid_wb),
    .mem_error(mem_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic v, rd, wr; logic [31:0] res;
    logic e_vwb, e_err; logic [31:0] e_res;
  } vec_t;

  // One instruction through the stage, acting as memory with ack after dly
  // waiting cycles. Expected behaviour comes from the transaction rules:
  // stall cycles = 1 + min(dly, T-1) for legal ops, abort when dly >= T.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] res,
                        input logic [31:0] rt, input int dly, input logic [31:0] rdata);
    logic mop, legal, tmo, acc;
    int   exp_stalls, stalls;
    mop   = rd | wr;
    legal = mop && (res[1:0] == 2'b00) && !(rd && wr);
    tmo   = legal && (dly >= T);
    exp_stalls = !legal ? 0 : 1 + ((dly < T) ? dly : T - 1);
    valid_in = 1; mem_read = rd; mem_write = wr; result = res; registro_2 = rt;
    dmem_rdata = rdata;
    stalls = 0; acc = 0;
    for (int c = 0; c < 30 && !acc; c++) begin
      dmem_ack = legal && (c >= 1) && (c == dly + 1);
      #1;
      if (legal && c >= 1) begin
        chk("req_held", {31'b0, dmem_req}, 32'd1);
        chk("addr_held", dmem_addr, res);
        chk("we_held", {31'b0, dmem_we}, {31'b0, wr});
        if (wr) chk("wdata_held", dmem_wdata, rt);
      end
      if (stall) stalls++; else acc = 1;
      @(negedge clock);
    end
    valid_in = 0; mem_read = 0; mem_write = 0; dmem_ack = 0;
    chk("accepted", {31'b0, acc}, 32'd1);
    chk("stall_cycles", stalls, exp_stalls);
    chk("valid_wb", {31'b0, valid_wb}, 32'd1);
    chk("mem_error", {31'b0, mem_error}, {31'b0, (mop && !legal) || tmo});
    chk("req_dropped", {31'b0, dmem_req}, 32'd0);
    if (!tmo) chk("result_wb", result_wb, res);
    if (!mop)             begin m_dato = 0; m_dato_known = 1; end
    else if (!legal || tmo) m_dato_known = 0;
    else if (rd)          begin m_dato = rdata; m_dato_known = 1; end
    if (m_dato_known) chk("dato_leido", dato_leido, m_dato);
  endtask

  vec_t vt[6];

  initial begin
    // Reset state
    #2;
    chk("rst_req", {31'b0, dmem_req}, 0);
    chk("rst_valid_wb", {31'b0, valid_wb}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_dato", dato_leido, 0);
    chk("rst_result_wb", result_wb, 0);
    @(negedge clock); reset_n = 1;
    @(negedge clock);

    // Single-cycle table: ALU ops, idle, rejected memory ops.
    vt[0] = '{1, 0, 0, 32'h0000_1234, 1, 0, 32'h0000_1234};
    vt[1] = '{0, 0, 0, 32'h0000_5555, 0, 0, 32'h0000_1234};
    vt[2] = '{1, 1, 0, 32'h0000_0102, 1, 1, 32'h0000_0102};
    vt[3] = '{1, 1, 1, 32'h0000_0300, 1, 1, 32'h0000_0300};
    vt[4] = '{1, 0, 1, 32'h0000_0203, 1, 1, 32'h0000_0203};
    vt[5] = '{0, 1, 0, 32'h0000_0400, 0, 0, 32'h0000_0203};
    for (int i = 0; i < 6; i++) begin
      valid_in = vt[i].v; mem_read = vt[i].rd; mem_write = vt[i].wr;
      result = vt[i].res; registro_2 = 32'h1111_2222;
      #1;
      chk($sformatf("tbl%0d_stall", i), {31'b0, stall}, 0);
      @(negedge clock);
      chk($sformatf("tbl%0d_req", i), {31'b0, dmem_req}, 0);
      chk($sformatf("tbl%0d_vwb", i), {31'b0, valid_wb}, {31'b0, vt[i].e_vwb});
      chk($sformatf("tbl%0d_err", i), {31'b0, mem_error}, {31'b0, vt[i].e_err});
      chk($sformatf("tbl%0d_res", i), result_wb, vt[i].e_res);
    end
    valid_in = 0; mem_read = 0; mem_write = 0;
    @(negedge clock);
    m_dato_known = 0;

    // Load with 3 waiting cycles, then same-cycle-ack store, back to back.
    run_op(1, 0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
    run_op(0, 1, 32'h200, 32'hCAFE_F00D, 0, 32'h0);

    // Timeout, then a late ack in the following IDLE cycle is ignored.
    run_op(1, 0, 32'h180, 32'h0, 100, 32'h1234_5678);
    dmem_ack = 1;
    @(negedge clock);
    chk("late_ack_vwb", {31'b0, valid_wb}, 0);
    chk("late_ack_err", {31'b0, mem_error}, 0);
    chk("late_ack_req", {31'b0, dmem_req}, 0);
    dmem_ack = 0;

    // Reset during ACCESS.
    valid_in = 1; mem_read = 1; result = 32'h400;
    @(negedge clock); @(negedge clock);
    chk("pre_rst_req", {31'b0, dmem_req}, 1);
    #2 reset_n = 0; #1;
    chk("mid_rst_req", {31'b0, dmem_req}, 0);
    chk("mid_rst_stall", {31'b0, stall}, 0);
    chk("mid_rst_vwb", {31'b0, valid_wb}, 0);
    @(negedge clock);
    reset_n = 1; valid_in = 0; mem_read = 0;
    m_dato = 0; m_dato_known = 1;
    @(negedge clock);
    run_op(1, 0, 32'h104, 32'h0, 1, 32'hA5A5_0001);

    // Random instruction stream, occasional bubbles.
    for (int i = 0; i < 60; i++) begin
      int kind; logic [31:0] a;
      kind = $urandom_range(0, 4);
      a = {$urandom_range(0, 32'hFFFF), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case (kind)
        0: run_op(0, 0, $urandom, 0, 0, 0);
        1: run_op(1, 0, a, 0, $urandom_range(0, 5), $urandom);
        2: run_op(0, 1, a, $urandom, $urandom_range(0, 5), 0);
        3: run_op(1, 1, a, $urandom, 0, 0);
        default: begin
          @(negedge clock);
          chk("bubble_vwb", {31'b0, valid_wb}, 0);
          chk("bubble_err", {31'b0, mem_error}, 0);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
